// File: rtl/neuron_pkg.sv
// Shared types and fixed-point helpers for the neuron training datapath.
// sat_shift works on a wide sign-extended product so any DATA_WIDTH up to 64 can reuse it.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] p,
        input int                       shift,
        input int                       dw
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = p >>> shift;
        hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (dw - 1));
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage

// File: rtl/neuron_sat_mul.sv
// Combinational signed multiply, arithmetic right shift and saturation to DATA_WIDTH.
module neuron_sat_mul
    import neuron_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 0
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y
);

    logic signed [2*DATA_WIDTH-1:0] p;

    assign p = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    assign y = DATA_WIDTH'(sat_shift(SAT_W'(p), SHIFT, DATA_WIDTH));

endmodule

// File: rtl/neuron_backprop.sv
// Backward pass of the sequential MAC neuron: fans one error delta out into
// err_out[i] = delta*w[i] and grad_w[i] = delta*a[i], one index per cycle, then grad_b = delta.
module neuron_backprop
    import neuron_pkg::*;
#(
    parameter int INPUT_WIDTH = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] delta_in,
    input  logic signed [DATA_WIDTH-1:0] a_in [INPUT_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] w_in [INPUT_WIDTH],
    input  logic                         valid_in,
    output logic                         busy,
    output logic signed [DATA_WIDTH-1:0] err_out [INPUT_WIDTH],
    output logic signed [DATA_WIDTH-1:0] grad_w [INPUT_WIDTH],
    output logic signed [DATA_WIDTH-1:0] grad_b,
    output logic                         valid_out
);

    localparam int              IDX_W    = $clog2(INPUT_WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_WIDTH - 1);

    state_t                        state;
    logic [IDX_W-1:0]              idx;
    logic signed [DATA_WIDTH-1:0]  delta_p0;
    logic signed [DATA_WIDTH-1:0]  a_p0 [INPUT_WIDTH];
    logic signed [DATA_WIDTH-1:0]  w_p0 [INPUT_WIDTH];
    logic signed [DATA_WIDTH-1:0]  a_sel;
    logic signed [DATA_WIDTH-1:0]  w_sel;
    logic signed [DATA_WIDTH-1:0]  err_val;
    logic signed [DATA_WIDTH-1:0]  grad_val;

    // Operand select by comparison keeps the index width independent of the array bounds.
    always_comb begin
        a_sel = '0;
        w_sel = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            if (idx == IDX_W'(i)) begin
                a_sel = a_p0[i];
                w_sel = w_p0[i];
            end
        end
    end

    neuron_sat_mul #(.DATA_WIDTH(DATA_WIDTH), .SHIFT(SHIFT)) u_mul_w (
        .a (delta_p0),
        .b (w_sel),
        .y (err_val)
    );

    neuron_sat_mul #(.DATA_WIDTH(DATA_WIDTH), .SHIFT(SHIFT)) u_mul_a (
        .a (delta_p0),
        .b (a_sel),
        .y (grad_val)
    );

    // p0: capture stage; results written one index per edge in COMPUTE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            valid_out <= 1'b0;
            grad_b    <= '0;
            delta_p0  <= '0;
            for (int i = 0; i < INPUT_WIDTH; i++) begin
                a_p0[i]    <= '0;
                w_p0[i]    <= '0;
                err_out[i] <= '0;
                grad_w[i]  <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        delta_p0 <= delta_in;
                        for (int i = 0; i < INPUT_WIDTH; i++) begin
                            a_p0[i] <= a_in[i];
                            w_p0[i] <= w_in[i];
                        end
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int i = 0; i < INPUT_WIDTH; i++) begin
                        if (idx == IDX_W'(i)) begin
                            err_out[i] <= err_val;
                            grad_w[i]  <= grad_val;
                        end
                    end
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX)
                        state <= DONE;
                end
                DONE: begin
                    grad_b    <= delta_p0;
                    valid_out <= 1'b1;
                    idx       <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    idx   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_backprop.sv
// Self-checking bench for neuron_backprop: directed and random jobs against an arithmetic reference model.
module tb_neuron_backprop;

    localparam int N  = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic signed [DW-1:0] delta_in;
    logic signed [DW-1:0] a_in [N];
    logic signed [DW-1:0] w_in [N];
    logic                 valid_in;
    logic                 valid_in1;
    logic signed [DW-1:0] a1 [1];
    logic signed [DW-1:0] w1 [1];

    logic                 busy0, valid0, busy1, valid1, busy2, valid2;
    logic signed [DW-1:0] err0 [N], gw0 [N], err1 [N], gw1 [N], err2 [1], gw2 [1];
    logic signed [DW-1:0] gb0, gb1, gb2;

    assign a1[0] = a_in[0];
    assign w1[0] = w_in[0];

    neuron_backprop #(.INPUT_WIDTH(N), .DATA_WIDTH(DW), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .delta_in(delta_in), .a_in(a_in), .w_in(w_in),
        .valid_in(valid_in), .busy(busy0), .err_out(err0), .grad_w(gw0), .grad_b(gb0),
        .valid_out(valid0));

    neuron_backprop #(.INPUT_WIDTH(N), .DATA_WIDTH(DW), .SHIFT(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .delta_in(delta_in), .a_in(a_in), .w_in(w_in),
        .valid_in(valid_in), .busy(busy1), .err_out(err1), .grad_w(gw1), .grad_b(gb1),
        .valid_out(valid1));

    neuron_backprop #(.INPUT_WIDTH(1), .DATA_WIDTH(DW), .SHIFT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .delta_in(delta_in), .a_in(a1), .w_in(w1),
        .valid_in(valid_in1), .busy(busy2), .err_out(err2), .grad_w(gw2), .grad_b(gb2),
        .valid_out(valid2));

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [DW-1:0] jd;
    logic signed [DW-1:0] ja [N];
    logic signed [DW-1:0] jw [N];
    logic signed [DW-1:0] exp_e0 [N], exp_g0 [N], exp_e1 [N], exp_g1 [N];

    // Reference: exact product, floor division by 2^sh, clamp to the signed DW range.
    function automatic longint ref_mul(longint d, longint x, int sh);
        longint p, s, dv, lim;
        p  = d * x;
        dv = longint'(1) << sh;
        if (p >= 0) s = p / dv;
        else        s = -((-p + dv - 1) / dv);
        lim = longint'(1) << (DW - 1);
        if (s > lim - 1) s = lim - 1;
        if (s < -lim)    s = -lim;
        return s;
    endfunction

    function automatic logic signed [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    task automatic load_job();
        delta_in = jd;
        for (int i = 0; i < N; i++) begin
            a_in[i]   = ja[i];
            w_in[i]   = jw[i];
            exp_e0[i] = DW'(ref_mul(jd, jw[i], 0));
            exp_g0[i] = DW'(ref_mul(jd, ja[i], 0));
            exp_e1[i] = DW'(ref_mul(jd, jw[i], 8));
            exp_g1[i] = DW'(ref_mul(jd, ja[i], 8));
        end
    endtask

    task automatic scramble();
        delta_in = rnd();
        for (int i = 0; i < N; i++) begin
            a_in[i] = rnd();
            w_in[i] = rnd();
        end
    endtask

    // Returns at the falling edge right after the capture edge E0, inputs already scrambled.
    task automatic start_job();
        @(negedge clk);
        load_job();
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        scramble();
    endtask

    task automatic wait_valid(output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        while (valid0 !== 1'b1 && cyc < 50) begin
            if (busy0 === 1'b1) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; valid_in1 = 1'b0;
        for (int i = 0; i < N; i++) begin a_in[i] = '0; w_in[i] = '0; end
        delta_in = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy0); end
        n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", valid0); end
        n_checks++; if (gb0 !== '0) begin n_fail++; $display("FAIL reset_grad_b: got %0d, expected 0", gb0); end
        for (int i = 0; i < N; i++) begin
            n_checks++; if (err0[i] !== '0 || gw0[i] !== '0) begin n_fail++;
                $display("FAIL reset_out[%0d]: got err %0d grad %0d, expected 0 0", i, err0[i], gw0[i]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc, bc;
        jd = 2; jw = '{3, -4, 5}; ja = '{1, 2, 3};
        start_job();
        wait_valid(cyc, bc);
        n_checks++; if (cyc !== N + 1) begin n_fail++; $display("FAIL basic_latency: got %0d, expected %0d", cyc, N + 1); end
        n_checks++; if (bc !== N + 1) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, expected %0d", bc, N + 1); end
        for (int i = 0; i < N; i++) begin
            n_checks++; if (err0[i] !== exp_e0[i]) begin n_fail++; $display("FAIL basic_err[%0d]: got %0d, expected %0d", i, err0[i], exp_e0[i]); end
            n_checks++; if (gw0[i] !== exp_g0[i]) begin n_fail++; $display("FAIL basic_grad_w[%0d]: got %0d, expected %0d", i, gw0[i], exp_g0[i]); end
        end
        n_checks++; if (gb0 !== 16'sd2) begin n_fail++; $display("FAIL basic_grad_b: got %0d, expected 2", gb0); end
        @(negedge clk);
        n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b, expected 0", valid0); end
    endtask

    task automatic test_saturation();
        int cyc, bc;
        jd = 300; jw = '{200, -200, 0}; ja = '{-300, 1, 0};
        start_job();
        wait_valid(cyc, bc);
        for (int i = 0; i < N; i++) begin
            n_checks++; if (err0[i] !== exp_e0[i]) begin n_fail++; $display("FAIL sat_err[%0d]: got %0d, expected %0d", i, err0[i], exp_e0[i]); end
            n_checks++; if (gw0[i] !== exp_g0[i]) begin n_fail++; $display("FAIL sat_grad_w[%0d]: got %0d, expected %0d", i, gw0[i], exp_g0[i]); end
        end
    endtask

    task automatic test_shift();
        int cyc, bc;
        jd = 256; jw = '{512, -3, 1}; ja = '{-1, 0, 256};
        start_job();
        wait_valid(cyc, bc);
        for (int i = 0; i < N; i++) begin
            n_checks++; if (err1[i] !== exp_e1[i]) begin n_fail++; $display("FAIL shift_err[%0d]: got %0d, expected %0d", i, err1[i], exp_e1[i]); end
            n_checks++; if (gw1[i] !== exp_g1[i]) begin n_fail++; $display("FAIL shift_grad_w[%0d]: got %0d, expected %0d", i, gw1[i], exp_g1[i]); end
        end
        jd = -3; jw = '{128, 7, -9}; ja = '{100, -100, 3};
        start_job();
        wait_valid(cyc, bc);
        n_checks++; if (err1[0] !== -16'sd2) begin n_fail++; $display("FAIL shift_floor: got %0d, expected -2", err1[0]); end
        for (int i = 1; i < N; i++) begin
            n_checks++; if (err1[i] !== exp_e1[i] || gw1[i] !== exp_g1[i]) begin n_fail++;
                $display("FAIL shift_neg[%0d]: got %0d/%0d, expected %0d/%0d", i, err1[i], gw1[i], exp_e1[i], exp_g1[i]); end
        end
    endtask

    task automatic test_random();
        int cyc, bc;
        for (int j = 0; j < 20; j++) begin
            jd = (j % 3 == 0) ? DW'($urandom_range(0, 40)) - 16'sd20 : rnd();
            for (int i = 0; i < N; i++) begin ja[i] = rnd(); jw[i] = rnd(); end
            start_job();
            wait_valid(cyc, bc);
            n_checks++; if (cyc !== N + 1 || valid1 !== 1'b1) begin n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d (shift dut valid %b), expected %0d", j, cyc, valid1, N + 1); end
            for (int i = 0; i < N; i++) begin
                n_checks++; if (err0[i] !== exp_e0[i] || gw0[i] !== exp_g0[i]) begin n_fail++;
                    $display("FAIL rand_s0[%0d.%0d]: got %0d/%0d, expected %0d/%0d", j, i, err0[i], gw0[i], exp_e0[i], exp_g0[i]); end
                n_checks++; if (err1[i] !== exp_e1[i] || gw1[i] !== exp_g1[i]) begin n_fail++;
                    $display("FAIL rand_s8[%0d.%0d]: got %0d/%0d, expected %0d/%0d", j, i, err1[i], gw1[i], exp_e1[i], exp_g1[i]); end
            end
            n_checks++; if (gb0 !== jd || gb1 !== jd) begin n_fail++;
                $display("FAIL rand_grad_b[%0d]: got %0d/%0d, expected %0d", j, gb0, gb1, jd); end
        end
    endtask

    task automatic test_busy_ignore();
        int first, pulses;
        first = 0; pulses = 0;
        jd = 7; jw = '{-2, 9, 11}; ja = '{4, -5, 6};
        start_job();
        for (int k = 1; k <= 12; k++) begin
            valid_in = (k == 2);
            if (k == 2) scramble();
            @(negedge clk);
            if (valid0 === 1'b1) begin pulses++; if (first == 0) first = k; end
            if (k == 4) begin
                for (int i = 0; i < N; i++) begin
                    n_checks++; if (err0[i] !== exp_e0[i] || gw0[i] !== exp_g0[i]) begin n_fail++;
                        $display("FAIL busy_ign_res[%0d]: got %0d/%0d, expected %0d/%0d", i, err0[i], gw0[i], exp_e0[i], exp_g0[i]); end
                end
            end
        end
        valid_in = 1'b0;
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_ign_pulses: got %0d, expected 1", pulses); end
        n_checks++; if (first !== N + 1) begin n_fail++; $display("FAIL busy_ign_latency: got %0d, expected %0d", first, N + 1); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL busy_ign_restart: got busy %b, expected 0", busy0); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc, cyc2;
        jd = -5; jw = '{1, 2, 3}; ja = '{-7, 8, -9};
        start_job();
        wait_valid(cyc, bc);
        for (int i = 0; i < N; i++) begin
            n_checks++; if (err0[i] !== exp_e0[i] || gw0[i] !== exp_g0[i]) begin n_fail++;
                $display("FAIL b2b_first[%0d]: got %0d/%0d, expected %0d/%0d", i, err0[i], gw0[i], exp_e0[i], exp_g0[i]); end
        end
        jd = rnd();
        for (int i = 0; i < N; i++) begin ja[i] = rnd(); jw[i] = rnd(); end
        load_job();
        valid_in = 1'b1;
        cyc2 = 0;
        do begin
            @(negedge clk);
            if (cyc2 == 0) begin valid_in = 1'b0; scramble(); end
            cyc2++;
        end while (valid0 !== 1'b1 && cyc2 < 50);
        n_checks++; if (cyc2 !== N + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d, expected %0d", cyc2, N + 2); end
        for (int i = 0; i < N; i++) begin
            n_checks++; if (err0[i] !== exp_e0[i] || gw0[i] !== exp_g0[i]) begin n_fail++;
                $display("FAIL b2b_second[%0d]: got %0d/%0d, expected %0d/%0d", i, err0[i], gw0[i], exp_e0[i], exp_g0[i]); end
        end
        n_checks++; if (gb0 !== jd) begin n_fail++; $display("FAIL b2b_grad_b: got %0d, expected %0d", gb0, jd); end
    endtask

    task automatic test_reset_mid();
        int pulses, busy_seen, cyc, bc;
        pulses = 0; busy_seen = 0;
        jd = 1000; jw = '{3, 3, 3}; ja = '{5, 5, 5};
        start_job();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (busy0 !== 1'b0 || valid0 !== 1'b0 || gb0 !== '0) begin n_fail++;
            $display("FAIL rst_mid_ctrl: got busy %b valid %b grad_b %0d, expected 0 0 0", busy0, valid0, gb0); end
        for (int i = 0; i < N; i++) begin
            n_checks++; if (err0[i] !== '0 || gw0[i] !== '0) begin n_fail++;
                $display("FAIL rst_mid_out[%0d]: got %0d/%0d, expected 0/0", i, err0[i], gw0[i]); end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid0 === 1'b1) pulses++;
            if (busy0 === 1'b1) busy_seen++;
        end
        n_checks++; if (pulses !== 0 || busy_seen !== 0) begin n_fail++;
            $display("FAIL rst_mid_quiet: got %0d pulses %0d busy cycles, expected 0 0", pulses, busy_seen); end
        jd = rnd();
        for (int i = 0; i < N; i++) begin ja[i] = rnd(); jw[i] = rnd(); end
        start_job();
        wait_valid(cyc, bc);
        n_checks++; if (cyc !== N + 1) begin n_fail++; $display("FAIL rst_mid_fresh_latency: got %0d, expected %0d", cyc, N + 1); end
        for (int i = 0; i < N; i++) begin
            n_checks++; if (err0[i] !== exp_e0[i] || gw0[i] !== exp_g0[i]) begin n_fail++;
                $display("FAIL rst_mid_fresh[%0d]: got %0d/%0d, expected %0d/%0d", i, err0[i], gw0[i], exp_e0[i], exp_g0[i]); end
        end
    endtask

    task automatic test_single_input();
        int cyc, bc;
        logic signed [DW-1:0] e_err, e_grad;
        jd = -20000; jw = '{3, 0, 0}; ja = '{-2, 0, 0};
        e_err  = DW'(ref_mul(jd, jw[0], 0));
        e_grad = DW'(ref_mul(jd, ja[0], 0));
        @(negedge clk);
        load_job();
        valid_in1 = 1'b1;
        @(negedge clk);
        valid_in1 = 1'b0;
        scramble();
        cyc = 0; bc = 0;
        while (valid2 !== 1'b1 && cyc < 50) begin
            if (busy2 === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (cyc !== 2 || bc !== 2) begin n_fail++;
            $display("FAIL n1_timing: got latency %0d busy %0d, expected 2 2", cyc, bc); end
        n_checks++; if (err2[0] !== e_err || gw2[0] !== e_grad || gb2 !== jd) begin n_fail++;
            $display("FAIL n1_result: got %0d/%0d/%0d, expected %0d/%0d/%0d", err2[0], gw2[0], gb2, e_err, e_grad, jd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_shift();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_single_input();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
